// File: rtl/button_pkg.sv
// Shared types, counter-width helper and 100 MHz board timing constants for button_bank.
package button_pkg;

   // 100 MHz board build: 10 ms debounce, 50 ms lockout, 1 s long press, 200 ms repeat
   localparam int BOARD_DEB_CYCLES     = 1_000_000;
   localparam int BOARD_LOCKOUT_CYCLES = 5_000_000;
   localparam int BOARD_LONG_CYCLES    = 100_000_000;
   localparam int BOARD_REPEAT_CYCLES  = 20_000_000;

   typedef struct packed {
      logic level;
      logic press;
      logic release_pulse;
      logic long_press;
      logic repeat_pulse;
   } btn_evt_t;

   function automatic int cnt_w(input int max_val);
      if (max_val < 1) return 1;
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: 2-flop sync, debounce, press/release pulses, press lockout,
// long-press detect and (with BUTTON_BANK_REPEAT_EN) auto-repeat.
module button_channel
   import button_pkg::*;
#(
   parameter int DEB_CYCLES     = 16,
   parameter int LOCKOUT_CYCLES = 0,
   parameter int LONG_CYCLES    = 1000,
   parameter int REPEAT_CYCLES  = 200
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     btn,
   output btn_evt_t evt
);

   localparam int DW = cnt_w(DEB_CYCLES);
   localparam int HW = cnt_w(LONG_CYCLES);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
   localparam logic [HW-1:0] LONG_MAX  = HW'(LONG_CYCLES);
   localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);

   if (DEB_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1 || LOCKOUT_CYCLES < 0) begin : g_bad_param
      $error("button_channel: illegal timing parameters");
   end

   logic          sync_p0;
   logic          sync_p1;
   logic [DW-1:0] dcnt;
   logic          level_q;
   logic          press_q;
   logic          release_q;
   logic [HW-1:0] hcnt;
   logic          long_q;
   logic          repeat_q;
   logic          lock_active;
   logic          accept;
   logic          rise_acc;

   assign accept   = (sync_p1 != level_q) && (dcnt == DEB_LAST);
   assign rise_acc = accept && sync_p1;

   // stage p0/p1: metastability synchroniser
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
      end
   end

   // debounce: any cycle agreeing with the current level restarts the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dcnt      <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         press_q   <= rise_acc && !lock_active;
         release_q <= accept && !sync_p1;
         if (accept) begin
            level_q <= sync_p1;
            dcnt    <= '0;
         end else if (sync_p1 != level_q) begin
            dcnt <= dcnt + 1'b1;
         end else begin
            dcnt <= '0;
         end
      end
   end

   if (LOCKOUT_CYCLES > 0) begin : g_lock
      localparam int LW = cnt_w(LOCKOUT_CYCLES);
      localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);
      logic [LW-1:0] lcnt;

      // only an emitted press re-arms the window; suppressed rises do not extend it
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            lcnt <= '0;
         end else if (rise_acc && lcnt == '0) begin
            lcnt <= LOCK_LOAD;
         end else if (lcnt != '0) begin
            lcnt <= lcnt - 1'b1;
         end
      end
      assign lock_active = (lcnt != '0);
   end else begin : g_no_lock
      assign lock_active = 1'b0;
   end

   // long press: hcnt saturates so long_press fires once per hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt   <= '0;
         long_q <= 1'b0;
      end else begin
         long_q <= 1'b0;
         if (!level_q) begin
            hcnt <= '0;
         end else if (hcnt != LONG_MAX) begin
            hcnt <= hcnt + 1'b1;
            if (hcnt == LONG_LAST) long_q <= 1'b1;
         end
      end
   end

`ifdef BUTTON_BANK_REPEAT_EN
   localparam int RW = cnt_w(REPEAT_CYCLES);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
   logic [RW-1:0] rcnt;

   // repeat period starts counting the cycle after long_press
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rcnt     <= '0;
         repeat_q <= 1'b0;
      end else begin
         repeat_q <= 1'b0;
         if (!level_q) begin
            rcnt <= '0;
         end else if (hcnt == LONG_MAX) begin
            if (rcnt == REP_LAST) begin
               rcnt     <= '0;
               repeat_q <= 1'b1;
            end else begin
               rcnt <= rcnt + 1'b1;
            end
         end
      end
   end
`else
   assign repeat_q = 1'b0;
`endif

   assign evt = '{level:         level_q,
                  press:         press_q,
                  release_pulse: release_q,
                  long_press:    long_q,
                  repeat_pulse:  repeat_q};

endmodule

// File: rtl/button_bank.sv
// N_CH-channel push-button conditioner; optional auto-repeat via BUTTON_BANK_REPEAT_EN.
// release/repeat are SystemVerilog keywords, hence the release_pulse/repeat_pulse port names.
module button_bank
   import button_pkg::*;
#(
   parameter int N_CH           = 4,
   parameter int DEB_CYCLES     = 16,
   parameter int LOCKOUT_CYCLES = 0,
   parameter int LONG_CYCLES    = 1000,
   parameter int REPEAT_CYCLES  = 200
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] press,
   output logic [N_CH-1:0] release_pulse,
   output logic [N_CH-1:0] long_press,
   output logic [N_CH-1:0] repeat_pulse
);

   if (N_CH < 1) begin : g_bad_n_ch
      $error("button_bank: N_CH must be at least 1");
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      btn_evt_t evt;

      button_channel #(
         .DEB_CYCLES     (DEB_CYCLES),
         .LOCKOUT_CYCLES (LOCKOUT_CYCLES),
         .LONG_CYCLES    (LONG_CYCLES),
         .REPEAT_CYCLES  (REPEAT_CYCLES)
      ) u_ch (
         .clk (clk),
         .rst (rst),
         .btn (btn[i]),
         .evt (evt)
      );

      assign level[i]         = evt.level;
      assign press[i]         = evt.press;
      assign release_pulse[i] = evt.release_pulse;
      assign long_press[i]    = evt.long_press;
      assign repeat_pulse[i]  = evt.repeat_pulse;
   end

endmodule
